// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS channel decoder:
//   - the four DVI control-token code words (bit 9 is the MSB)
//   - tok_lookup(): maps a 10-bit word to {hit, ctrl}
//   - tmds_state_t: alignment FSM states
//   - SLIP_LAST: highest word offset the aligner can select
// ---------------------------------------------------------------------------
package tmds_pkg;

   localparam logic [9:0] TOK_C00 = 10'h354;
   localparam logic [9:0] TOK_C01 = 10'h0AB;
   localparam logic [9:0] TOK_C10 = 10'h154;
   localparam logic [9:0] TOK_C11 = 10'h2AB;

   localparam logic [3:0] SLIP_LAST = 4'd9;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SLIP   = 2'd1,
      ST_LOCKED = 2'd2
   } tmds_state_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] ctrl;
   } tok_info_t;

   function automatic tok_info_t tok_lookup(input logic [9:0] q);
      tok_info_t t;
      t.hit  = 1'b1;
      t.ctrl = 2'b00;
      case (q)
         TOK_C00: t.ctrl = 2'b00;
         TOK_C01: t.ctrl = 2'b01;
         TOK_C10: t.ctrl = 2'b10;
         TOK_C11: t.ctrl = 2'b11;
         default: t.hit  = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_word_align.sv
// ---------------------------------------------------------------------------
// tmds_word_align
// Holds the previous deserialized word and the current word offset, and
// selects the 10-bit window starting at bit slip_pos of {sym_in, previous}.
// Ports:
//   clk_pix  - pixel clock
//   rst      - synchronous active-high reset (offset and history cleared)
//   sym_in   - raw 10-bit word, bit 0 received first
//   slip     - advance the offset by one bit (wraps 9 -> 0)
//   win      - selected 10-bit window (combinational from sym_in/history)
//   slip_pos - current offset 0..9
// ---------------------------------------------------------------------------
module tmds_word_align
   import tmds_pkg::*;
(
   input  logic       clk_pix,
   input  logic       rst,
   input  logic [9:0] sym_in,
   input  logic       slip,
   output logic [9:0] win,
   output logic [3:0] slip_pos
);

   logic [9:0]  r_prev;
   logic [3:0]  r_slip_pos;
   // sym_in[9] is never inside a window with offset <= 9, so it is left out here
   logic [18:0] w_cat;
   logic [9:0]  w_cand [10];

   assign w_cat = {sym_in[8:0], r_prev};

   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_cand
         assign w_cand[gi] = w_cat[gi +: 10];
      end
   endgenerate

   always_comb begin
      win = w_cand[0];
      for (int k = 1; k < 10; k++) begin
         if (r_slip_pos == 4'(k)) win = w_cand[k];
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         r_prev     <= '0;
         r_slip_pos <= '0;
      end else begin
         r_prev <= sym_in;
         if (slip) r_slip_pos <= (r_slip_pos == SLIP_LAST) ? 4'd0 : r_slip_pos + 4'd1;
      end
   end

   assign slip_pos = r_slip_pos;

endmodule

// File: rtl/tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_decoder
// Word-aligns one TMDS channel by hunting for runs of control tokens, then
// decodes video bytes and control values. Latency sym_in -> outputs is two
// cycles: the aligner's history register, then the decode register.
// Parameters:
//   LOCK_TOKENS - consecutive aligned control tokens needed to lock
//   TIMEOUT     - cycles without success before slipping / unlocking
// Ports:
//   clk_pix, rst      - pixel clock, synchronous active-high reset
//   sym_in[9:0]       - raw deserialized word
//   data[7:0]         - decoded video byte (0 unless de)
//   ctrl[1:0]         - last decoded control value {C1,C0}
//   de                - data holds valid video
//   locked            - alignment achieved
//   slip_pos[3:0]     - current word offset
//   err               - one-cycle pulse on each lock loss (not on reset)
//   err_cnt[15:0]     - saturating lock-loss count, only when the
//                       TMDS_DEC_ERRCNT_EN macro is defined
// ---------------------------------------------------------------------------
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS = 8,
   parameter int TIMEOUT     = 2048
) (
   input  logic        clk_pix,
   input  logic        rst,
   input  logic [9:0]  sym_in,
   output logic [7:0]  data,
   output logic [1:0]  ctrl,
   output logic        de,
   output logic        locked,
   output logic [3:0]  slip_pos,
   output logic        err
`ifdef TMDS_DEC_ERRCNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
   localparam int TIM_W = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_TOKENS);
   localparam logic [TIM_W-1:0] TIM_MAX  = TIM_W'(TIMEOUT);
   localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT - 1);

   tmds_state_t      r_state, w_state_next;
   logic [RUN_W-1:0] r_run, w_run_next, w_run_inc;
   logic [TIM_W-1:0] r_timer, w_timer_next, w_timer_inc;
   logic             w_slip, w_err_next;
   logic [9:0]       w_win;
   tok_info_t        w_tok;
   logic [7:0]       w_d, w_dec;
   logic [7:0]       r_data;
   logic [1:0]       r_ctrl;
   logic             r_de, r_locked, r_err;

   tmds_word_align u_align (
      .clk_pix  (clk_pix),
      .rst      (rst),
      .sym_in   (sym_in),
      .slip     (w_slip),
      .win      (w_win),
      .slip_pos (slip_pos)
   );

   assign w_tok = tok_lookup(w_win);

   // Undo the optional inversion, then the XOR/XNOR transition chain
   assign w_d      = w_win[9] ? ~w_win[7:0] : w_win[7:0];
   assign w_dec[0] = w_d[0];
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_dec
         assign w_dec[gi] = w_win[8] ? (w_d[gi] ^ w_d[gi-1]) : ~(w_d[gi] ^ w_d[gi-1]);
      end
   endgenerate

   assign w_run_inc   = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
   assign w_timer_inc = (r_timer == TIM_MAX) ? r_timer : r_timer + TIM_W'(1);

   always_comb begin
      w_state_next = r_state;
      w_run_next   = r_run;
      w_timer_next = r_timer;
      w_slip       = 1'b0;
      w_err_next   = 1'b0;
      case (r_state)
         ST_HUNT: begin
            w_run_next = w_tok.hit ? w_run_inc : '0;
            if (w_tok.hit && (w_run_inc == RUN_MAX)) begin
               w_state_next = ST_LOCKED;
               w_run_next   = '0;
               w_timer_next = '0;
            end else if (r_timer == TIM_LAST) begin
               w_state_next = ST_SLIP;
            end else begin
               w_timer_next = w_timer_inc;
            end
         end
         ST_SLIP: begin
            w_slip       = 1'b1;
            w_state_next = ST_HUNT;
            w_run_next   = '0;
            w_timer_next = '0;
         end
         ST_LOCKED: begin
            // Timer measures the gap since the last aligned token
            if (w_tok.hit) begin
               w_timer_next = '0;
            end else if (r_timer == TIM_LAST) begin
               w_state_next = ST_HUNT;
               w_err_next   = 1'b1;
               w_timer_next = '0;
               w_run_next   = '0;
            end else begin
               w_timer_next = w_timer_inc;
            end
         end
         default: begin
            w_state_next = ST_HUNT;
            w_run_next   = '0;
            w_timer_next = '0;
         end
      endcase
   end

   // Outputs are gated by the state being entered so they always agree with locked
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         r_state  <= ST_HUNT;
         r_run    <= '0;
         r_timer  <= '0;
         r_data   <= '0;
         r_ctrl   <= '0;
         r_de     <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_run    <= w_run_next;
         r_timer  <= w_timer_next;
         r_locked <= (w_state_next == ST_LOCKED);
         r_err    <= w_err_next;
         if (w_state_next == ST_LOCKED) begin
            if (w_tok.hit) begin
               r_data <= '0;
               r_de   <= 1'b0;
               r_ctrl <= w_tok.ctrl;
            end else begin
               r_data <= w_dec;
               r_de   <= 1'b1;
            end
         end else begin
            r_data <= '0;
            r_de   <= 1'b0;
            r_ctrl <= '0;
         end
      end
   end

`ifdef TMDS_DEC_ERRCNT_EN
   logic [15:0] r_err_cnt;
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_err_next && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end
   assign err_cnt = r_err_cnt;
`endif

   assign data   = r_data;
   assign ctrl   = r_ctrl;
   assign de     = r_de;
   assign locked = r_locked;
   assign err    = r_err;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_decoder
// Directed scenarios with random video content, every cycle compared against
// a behavioural model of the alignment/decode rules, plus directed checks of
// lock timing, 2-cycle latency, lock loss, reset dominance and offset wrap.
// ---------------------------------------------------------------------------
module tb_tmds_channel_decoder;

   localparam int LOCK_TOKENS = 8;
   localparam int TIMEOUT     = 2048;
   localparam int M_HUNT = 0, M_SLIP = 1, M_LOCKED = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sym_in;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       de, locked, err;
   logic [3:0] slip_pos;
`ifdef TMDS_DEC_ERRCNT_EN
   logic [15:0] err_cnt;
`endif

   tmds_channel_decoder #(.LOCK_TOKENS(LOCK_TOKENS), .TIMEOUT(TIMEOUT)) dut (
      .clk_pix  (clk),
      .rst      (rst),
      .sym_in   (sym_in),
      .data     (data),
      .ctrl     (ctrl),
      .de       (de),
      .locked   (locked),
      .slip_pos (slip_pos),
      .err      (err)
`ifdef TMDS_DEC_ERRCNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   // Behavioural model state
   logic [9:0] m_prev;
   int         m_slip, m_state, m_run, m_timer, m_errcnt;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;
   logic       m_de, m_locked, m_err;

   logic [9:0] last_true;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int tok_index(input logic [9:0] w);
      for (int i = 0; i < 4; i++) if (w == tokens[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] q);
      logic [7:0] d, o;
      d    = q[9] ? ~q[7:0] : q[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   // DVI-style encoder: transition-minimised byte, optional inversion
   function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
      logic [7:0] qm;
      int         ones;
      logic       use_xnor;
      ones     = $countones(d);
      use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      return {inv, ~use_xnor, inv ? ~qm : qm};
   endfunction

   function automatic logic [9:0] rand_data();
      return tmds_enc(8'($urandom), 1'($urandom));
   endfunction

   task automatic model_edge(input logic [9:0] s, input logic r);
      logic [19:0] cat;
      logic [9:0]  win;
      int          tix, nstate;
      if (r) begin
         m_prev = '0; m_slip = 0; m_state = M_HUNT; m_run = 0; m_timer = 0;
         m_data = '0; m_ctrl = '0; m_de = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_errcnt = 0;
         return;
      end
      cat    = {s, m_prev};
      win    = 10'(cat >> m_slip);
      tix    = tok_index(win);
      m_err  = 1'b0;
      nstate = m_state;
      if (m_state == M_HUNT) begin
         m_run = (tix >= 0) ? m_run + 1 : 0;
         if (m_run >= LOCK_TOKENS) begin
            nstate = M_LOCKED; m_run = 0; m_timer = 0;
         end else begin
            m_timer++;
            if (m_timer >= TIMEOUT) nstate = M_SLIP;
         end
      end else if (m_state == M_SLIP) begin
         m_slip = (m_slip + 1) % 10; m_run = 0; m_timer = 0; nstate = M_HUNT;
      end else begin
         if (tix >= 0) m_timer = 0;
         else begin
            m_timer++;
            if (m_timer >= TIMEOUT) begin
               nstate = M_HUNT; m_err = 1'b1; m_timer = 0; m_run = 0;
               if (m_errcnt < 65535) m_errcnt++;
            end
         end
      end
      m_state  = nstate;
      m_locked = (nstate == M_LOCKED);
      if (!m_locked) begin
         m_data = '0; m_de = 1'b0; m_ctrl = '0;
      end else if (tix >= 0) begin
         m_data = '0; m_de = 1'b0; m_ctrl = 2'(tix);
      end else begin
         m_data = ref_decode(win); m_de = 1'b1;
      end
      m_prev = s;
   endtask

   task automatic compare_all();
      chk("data", 32'(data), 32'(m_data));
      chk("ctrl", 32'(ctrl), 32'(m_ctrl));
      chk("de", 32'(de), 32'(m_de));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("slip_pos", 32'(slip_pos), 32'(m_slip));
      chk("err", 32'(err), 32'(m_err));
`ifdef TMDS_DEC_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
   endtask

   task automatic step(input logic [9:0] s, input logic r);
      sym_in = s;
      rst    = r;
      @(posedge clk);
      model_edge(s, r);
      @(negedge clk);
      compare_all();
   endtask

   // True word boundary sits 3 bits into the deserialized word
   task automatic send_shift3(input logic [9:0] t);
      step({t[6:0], last_true[9:7]}, 1'b0);
      last_true = t;
   endtask

   initial begin
      int pulses, drop_at, changes;
      logic [3:0] seen_slip;

      sym_in = '0;
      rst    = 1'b1;

      // Reset state
      step(10'h000, 1'b1);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_slip", 32'(slip_pos), 32'd0);
      chk("rst_de", 32'(de), 32'd0);

      // Lock on repeated 10'h354 at offset 0
      for (int i = 1; i <= 9; i++) begin
         step(10'h354, 1'b0);
         if (i == 8) chk("lock_cycle8", 32'(locked), 32'd0);
      end
      chk("lock_cycle9", 32'(locked), 32'd1);
      chk("lock_ctrl", 32'(ctrl), 32'd0);
      chk("lock_de", 32'(de), 32'd0);

      // 8'hA5 appears exactly two cycles after it is presented
      step(tmds_enc(8'hA5, 1'b0), 1'b0);
      chk("a5_de_early", 32'(de), 32'd0);
      step(10'h354, 1'b0);
      chk("a5_data", 32'(data), 32'hA5);
      chk("a5_de", 32'(de), 32'd1);

      // Random locked traffic: tokens of every kind mixed with video
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(1, 0) == 1) step(tokens[$urandom_range(3, 0)], 1'b0);
         else step(rand_data(), 1'b0);
      end

      // Lock loss after TIMEOUT token-free windows (window lags sym_in by one word)
      step(10'h354, 1'b0);
      pulses  = 0;
      drop_at = -1;
      for (int i = 1; i <= TIMEOUT + 4; i++) begin
         step(rand_data(), 1'b0);
         if (err === 1'b1) begin
            pulses++;
            drop_at = i;
         end
      end
      chk("loss_pulses", 32'(pulses), 32'd1);
      chk("loss_cycle", 32'(drop_at), 32'(TIMEOUT + 1));
      chk("loss_locked", 32'(locked), 32'd0);
`ifdef TMDS_DEC_ERRCNT_EN
      chk("loss_err_cnt", 32'(err_cnt), 32'd1);
`endif

      // Reset while locked, same cycle as a token
      for (int i = 0; i < 10; i++) step(10'h2AB, 1'b0);
      chk("relock", 32'(locked), 32'd1);
      chk("relock_ctrl", 32'(ctrl), 32'd3);
      step(10'h354, 1'b1);
      chk("rst_lock_locked", 32'(locked), 32'd0);
      chk("rst_lock_err", 32'(err), 32'd0);
      chk("rst_lock_ctrl", 32'(ctrl), 32'd0);

      // Stream shifted by 3 bits, blanking and video alternating
      last_true = '0;
      changes   = 0;
      seen_slip = slip_pos;
      for (int i = 0; i < 4 * (TIMEOUT + 1) + 200 && locked !== 1'b1; i++) begin
         send_shift3((i % 50 < 20) ? 10'h354 : rand_data());
         if (slip_pos !== seen_slip) begin
            changes++;
            seen_slip = slip_pos;
         end
      end
      chk("shift3_locked", 32'(locked), 32'd1);
      chk("shift3_slip", 32'(slip_pos), 32'd3);
      chk("shift3_steps", 32'(changes), 32'd3);
      for (int i = 0; i < 100; i++) send_shift3((i % 50 < 20) ? 10'h354 : rand_data());
      chk("shift3_hold", 32'(locked), 32'd1);

      // Offset wraps 9 -> 0 on a stream with no control tokens
      step(10'h000, 1'b1);
      for (int i = 0; i < 9 * (TIMEOUT + 1); i++) step(rand_data(), 1'b0);
      chk("wrap_at9", 32'(slip_pos), 32'd9);
      for (int i = 0; i < TIMEOUT + 1; i++) step(rand_data(), 1'b0);
      chk("wrap_to0", 32'(slip_pos), 32'd0);
      chk("wrap_locked", 32'(locked), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 8: consecutive aligned control tokens required to declare lock.
REQ-002 SHALL have parameter TIMEOUT, default 2048: clk_pix cycles allowed without success before slip (hunting) or unlock (locked).
REQ-003 SHALL have port clk_pix, input, 1: pixel clock, one 10-bit symbol per cycle; the single clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sym_in, input, 10: raw deserialized word, bit 0 received first.
REQ-006 SHALL have port data, output, 8: decoded video byte.
REQ-007 SHALL have port ctrl, output, 2: last decoded control value {C1,C0}.
REQ-008 SHALL have port de, output, 1: high when data is valid video.
REQ-009 SHALL have port locked, output, 1: alignment achieved.
REQ-010 SHALL have port slip_pos, output, 4: current word offset 0..9.
REQ-011 SHALL have port err, output, 1: one-cycle pulse on each lock loss.

Function
REQ-012 Alignment window SHALL be the 10 bits starting at bit slip_pos of {sym_in, previous sym_in} (20-bit concatenation, previous word in bits 9:0).
REQ-013 Control tokens SHALL be 10'h354->00, 10'h0AB->01, 10'h154->10, 10'h2AB->11 (bit 9 MSB).
REQ-014 Data decode: d = q[9] ? ~q[7:0] : q[7:0]; data[0]=d[0]; data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i=1..7.
REQ-015 Latency SHALL be exactly 2 cycles from sym_in to data/ctrl/de (align register, decode register).
REQ-016 FSM states SHALL be HUNT, SLIP, LOCKED.
REQ-017 HUNT: run counter increments on each aligned control token and clears on any non-token; at run == LOCK_TOKENS go to LOCKED.
REQ-018 HUNT: cycle timer counts cycles in HUNT; at TIMEOUT without lock go to SLIP.
REQ-019 SLIP: slip_pos <= (slip_pos == 9) ? 0 : slip_pos+1; one cycle; return to HUNT with run and timer cleared.
REQ-020 LOCKED: timer clears on every aligned control token; at TIMEOUT cycles since last token go to HUNT, locked low, err pulses one cycle; slip_pos retained.
REQ-021 locked SHALL be high only in LOCKED, registered, asserting the cycle after the LOCK_TOKENS-th token.
REQ-022 While not locked, data=0, de=0, ctrl=00.
REQ-023 While locked: control token -> de=0, ctrl updated, data=0; otherwise de=1, data decoded, ctrl held.
REQ-024 Counters SHALL saturate, never wrap; widths sized by $clog2 of parameters.

Reset
REQ-025 rst SHALL dominate all other events in the same cycle.
REQ-026 On rst: state HUNT, slip_pos=0, run=0, timer=0, data=0, ctrl=00, de=0, locked=0, err=0, pipeline registers 0.
REQ-027 rst mid-lock SHALL drop locked the next cycle without an err pulse.

Configuration
REQ-028 Macro TMDS_DEC_ERRCNT_EN defined: adds output err_cnt, 16 bits, incremented on each err pulse, saturating at 16'hFFFF, cleared by rst.
REQ-029 Macro undefined: err_cnt port and logic absent; all other behaviour identical.

Structure
REQ-030 Package tmds_pkg SHALL hold the four control-token constants, a token-to-ctrl lookup function, and the FSM state enum.
REQ-031 Sub-module tmds_word_align SHALL own the previous-word register, window select and slip_pos register; decode and FSM stay in the top.

Verification
REQ-032 Reset, then 10'h354 repeated with slip_pos already correct -> locked=1 on cycle 9 after first token (LOCK_TOKENS=8), ctrl=00, de=0.
REQ-033 Stream shifted by 3 bits, control and data lines alternating -> slip_pos steps 0..3 at TIMEOUT intervals, then locks at 3.
REQ-034 Locked, encoded byte 8'hA5 -> data=8'hA5, de=1 exactly 2 cycles later.
REQ-035 Locked, no token for 2048 cycles -> locked=0, single err pulse, err_cnt=1 (macro on).
REQ-036 rst asserted while locked, same cycle as token -> all outputs reset next cycle, err stays 0.
REQ-037 Misaligned stream, slip_pos=9 at SLIP -> wraps to 0.
